// File: rtl/fsab_req_arbiter_pkg.sv
// fsab_req_arbiter_pkg: FSAB field widths, beat packing layout and arbiter types.
package fsab_req_arbiter_pkg;
   localparam int FSAB_REQ_HI = 0;
   localparam int FSAB_DID_HI = 3;
   localparam int FSAB_ADDR_HI = 30;
   localparam int FSAB_LEN_HI = 3;
   localparam int FSAB_DATA_HI = 63;
   localparam int FSAB_MASK_HI = 7;
   localparam int FSAB_INITIAL_CREDITS = 4;
   localparam logic [FSAB_REQ_HI:0] FSAB_READ = 1'b0;
   localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;
   localparam int MODE_W = FSAB_REQ_HI + 1;
   localparam int DID_W = FSAB_DID_HI + 1;
   localparam int ADDR_W = FSAB_ADDR_HI + 1;
   localparam int LEN_W = FSAB_LEN_HI + 1;
   localparam int DATA_W = FSAB_DATA_HI + 1;
   localparam int MASK_W = FSAB_MASK_HI + 1;
   // Beat word is {mode, did, subdid, addr, len, data, mask}, mask in the LSBs.
   localparam int DATA_LO = MASK_W;
   localparam int LEN_LO = DATA_LO + DATA_W;
   localparam int ADDR_LO = LEN_LO + LEN_W;
   localparam int SUBDID_LO = ADDR_LO + ADDR_W;
   localparam int DID_LO = SUBDID_LO + DID_W;
   localparam int MODE_LO = DID_LO + DID_W;
   localparam int BEAT_W = MODE_LO + MODE_W;
   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
   function automatic logic [LEN_W-1:0] beat_count(input logic [BEAT_W-1:0] b);
      logic [LEN_W-1:0] len;
      len = b[LEN_LO +: LEN_W];
      return (b[MODE_LO +: MODE_W] == FSAB_WRITE && len != '0) ? len : LEN_W'(1);
   endfunction
endpackage

// File: rtl/fsab_arb_fifo.sv
// fsab_arb_fifo: per-client beat FIFO; a push into a full FIFO is dropped unless a pop frees the slot.
module fsab_arb_fifo #(
   parameter int W = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push;
   assign empty = wp == rp;
   assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign do_push = push && (!full || pop);
   assign head = mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/fsab_req_arbiter.sv
// fsab_req_arbiter: packet-granular round-robin of NCLIENT FSAB masters onto one upstream request port.
module fsab_req_arbiter
   import fsab_req_arbiter_pkg::*;
#(
   parameter int NCLIENT = 2,
   parameter int FIFO_DEPTH = FSAB_INITIAL_CREDITS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NCLIENT-1:0]          cli_valid,
   input  logic [NCLIENT*MODE_W-1:0]   cli_mode,
   input  logic [NCLIENT*DID_W-1:0]    cli_did,
   input  logic [NCLIENT*DID_W-1:0]    cli_subdid,
   input  logic [NCLIENT*ADDR_W-1:0]   cli_addr,
   input  logic [NCLIENT*LEN_W-1:0]    cli_len,
   input  logic [NCLIENT*DATA_W-1:0]   cli_data,
   input  logic [NCLIENT*MASK_W-1:0]   cli_mask,
   output logic [NCLIENT-1:0]          cli_credit,
   output logic                        fsabo_valid,
   output logic [FSAB_REQ_HI:0]        fsabo_mode,
   output logic [FSAB_DID_HI:0]        fsabo_did,
   output logic [FSAB_DID_HI:0]        fsabo_subdid,
   output logic [FSAB_ADDR_HI:0]       fsabo_addr,
   output logic [FSAB_LEN_HI:0]        fsabo_len,
   output logic [FSAB_DATA_HI:0]       fsabo_data,
   output logic [FSAB_MASK_HI:0]       fsabo_mask,
   input  logic                        fsabo_credit,
   output logic [NCLIENT-1:0]          err_overflow
);
   localparam int PW = NCLIENT > 1 ? $clog2(NCLIENT) : 1;
   localparam int CW = $clog2(FSAB_INITIAL_CREDITS) + 1;
   arb_state_t state, state_n;
   logic [PW-1:0] rr_ptr, rr_n, gnt, gnt_n, winner, sel;
   logic [LEN_W-1:0] beats_left, bl_n, n;
   logic [CW-1:0] up_credits;
   logic [CW:0] cred_sum;
   logic [NCLIENT-1:0] full, empty, pop;
   logic [BEAT_W-1:0] head [NCLIENT];
   logic [BEAT_W-1:0] sel_head;
   logic found, can_pop;
   int idx;
   for (genvar i = 0; i < NCLIENT; i++) begin : g_cli
      fsab_arb_fifo #(.W(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (cli_valid[i]),
         .din   ({cli_mode[i*MODE_W +: MODE_W], cli_did[i*DID_W +: DID_W],
                  cli_subdid[i*DID_W +: DID_W], cli_addr[i*ADDR_W +: ADDR_W],
                  cli_len[i*LEN_W +: LEN_W], cli_data[i*DATA_W +: DATA_W],
                  cli_mask[i*MASK_W +: MASK_W]}),
         .pop   (pop[i]),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );
   end
   always_comb begin
      found = 1'b0;
      winner = '0;
      idx = 0;
      for (int k = 0; k < NCLIENT; k++) begin
         idx = (int'(rr_ptr) + k) % NCLIENT;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            winner = PW'(idx);
         end
      end
      sel = state == ARB_BURST ? gnt : winner;
      sel_head = head[sel];
      n = beat_count(sel_head);
      // A burst owns the port until its last beat, even while its FIFO runs dry.
      can_pop = up_credits != '0 && (state == ARB_BURST ? !empty[gnt] : found);
      pop = can_pop ? NCLIENT'(1) << sel : '0;
      state_n = state;
      gnt_n = gnt;
      bl_n = beats_left;
      rr_n = rr_ptr;
      if (can_pop && state == ARB_IDLE) begin
         if (n > LEN_W'(1)) begin
            state_n = ARB_BURST;
            gnt_n = winner;
            bl_n = n - 1'b1;
         end else rr_n = winner == PW'(NCLIENT - 1) ? '0 : winner + 1'b1;
      end else if (can_pop) begin
         bl_n = beats_left - 1'b1;
         if (beats_left == LEN_W'(1)) begin
            state_n = ARB_IDLE;
            rr_n = gnt == PW'(NCLIENT - 1) ? '0 : gnt + 1'b1;
         end
      end
      cred_sum = {1'b0, up_credits} + (CW+1)'(fsabo_credit) - (CW+1)'(can_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
         gnt <= '0;
         beats_left <= '0;
         rr_ptr <= '0;
         up_credits <= CW'(FSAB_INITIAL_CREDITS);
         fsabo_valid <= 1'b0;
         {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask} <= '0;
         cli_credit <= '0;
         err_overflow <= '0;
      end else begin
         state <= state_n;
         gnt <= gnt_n;
         beats_left <= bl_n;
         rr_ptr <= rr_n;
         up_credits <= cred_sum > (CW+1)'(FSAB_INITIAL_CREDITS) ? CW'(FSAB_INITIAL_CREDITS) : cred_sum[CW-1:0];
         fsabo_valid <= can_pop;
         if (can_pop)
            {fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask} <= sel_head;
         cli_credit <= pop;
         err_overflow <= err_overflow | (cli_valid & full & ~pop);
      end
   end
endmodule

// File: tb/tb_fsab_req_arbiter.sv
// tb_fsab_req_arbiter: directed checks of framing, round-robin, credits, overflow and reset.
module tb_fsab_req_arbiter;
   import fsab_req_arbiter_pkg::*;
   localparam int N = 2;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] cli_valid, cli_credit, err_overflow;
   logic [N*MODE_W-1:0] cli_mode;
   logic [N*DID_W-1:0] cli_did, cli_subdid;
   logic [N*ADDR_W-1:0] cli_addr;
   logic [N*LEN_W-1:0] cli_len;
   logic [N*DATA_W-1:0] cli_data;
   logic [N*MASK_W-1:0] cli_mask;
   logic fsabo_valid, fsabo_credit;
   logic [FSAB_REQ_HI:0] fsabo_mode;
   logic [FSAB_DID_HI:0] fsabo_did, fsabo_subdid;
   logic [FSAB_ADDR_HI:0] fsabo_addr;
   logic [FSAB_LEN_HI:0] fsabo_len;
   logic [FSAB_DATA_HI:0] fsabo_data;
   logic [FSAB_MASK_HI:0] fsabo_mask;
   int checks = 0;
   int failures = 0;
   fsab_req_arbiter #(.NCLIENT(N), .FIFO_DEPTH(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .cli_valid    (cli_valid),
      .cli_mode     (cli_mode),
      .cli_did      (cli_did),
      .cli_subdid   (cli_subdid),
      .cli_addr     (cli_addr),
      .cli_len      (cli_len),
      .cli_data     (cli_data),
      .cli_mask     (cli_mask),
      .cli_credit   (cli_credit),
      .fsabo_valid  (fsabo_valid),
      .fsabo_mode   (fsabo_mode),
      .fsabo_did    (fsabo_did),
      .fsabo_subdid (fsabo_subdid),
      .fsabo_addr   (fsabo_addr),
      .fsabo_len    (fsabo_len),
      .fsabo_data   (fsabo_data),
      .fsabo_mask   (fsabo_mask),
      .fsabo_credit (fsabo_credit),
      .err_overflow (err_overflow)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input int c, input logic [FSAB_REQ_HI:0] mode, input logic [63:0] addr,
                       input logic [63:0] len, input logic [63:0] data);
      cli_valid[c] = 1'b1;
      cli_mode[c*MODE_W +: MODE_W] = mode;
      cli_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(addr);
      cli_len[c*LEN_W +: LEN_W] = LEN_W'(len);
      cli_data[c*DATA_W +: DATA_W] = DATA_W'(data);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      cli_valid = '0;
      tick();
      rst = 1'b0;
   endtask
   initial begin
      cli_valid = '0;
      cli_mode = '0;
      cli_did = '0;
      cli_subdid = '0;
      cli_addr = '0;
      cli_len = '0;
      cli_data = '0;
      cli_mask = '1;
      fsabo_credit = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(fsabo_valid), 0);
      chk("rst_credit", 64'(cli_credit), 0);
      chk("rst_err", 64'(err_overflow), 0);
      chk("rst_addr", 64'(fsabo_addr), 0);
      chk("rst_upcred", 64'(dut.up_credits), 4);
      rst = 1'b0;
      // single read, latency 2 from cli_valid
      beat(0, FSAB_READ, 64'h100, 8, 64'h0);
      tick();
      cli_valid = '0;
      chk("rd_lat1", 64'(fsabo_valid), 0);
      tick();
      chk("rd_valid", 64'(fsabo_valid), 1);
      chk("rd_addr", 64'(fsabo_addr), 64'h100);
      chk("rd_len", 64'(fsabo_len), 8);
      chk("rd_mask", 64'(fsabo_mask), 64'hff);
      chk("rd_clicred", 64'(cli_credit), 1);
      chk("rd_upcred", 64'(dut.up_credits), 3);
      tick();
      chk("rd_valid_off", 64'(fsabo_valid), 0);
      chk("rd_clicred_off", 64'(cli_credit), 0);
      fsabo_credit = 1'b1;
      tick();
      chk("cred_return", 64'(dut.up_credits), 4);
      tick();
      chk("cred_saturate", 64'(dut.up_credits), 4);
      // round robin
      do_reset();
      beat(0, FSAB_READ, 64'h200, 1, 0);
      beat(1, FSAB_READ, 64'h300, 1, 0);
      tick();
      cli_valid = '0;
      tick();
      chk("rr1_addr", 64'(fsabo_addr), 64'h200);
      chk("rr1_cred", 64'(cli_credit), 1);
      tick();
      chk("rr2_addr", 64'(fsabo_addr), 64'h300);
      chk("rr2_cred", 64'(cli_credit), 2);
      beat(0, FSAB_READ, 64'h400, 1, 0);
      tick();
      cli_valid = '0;
      tick();
      chk("rr3_addr", 64'(fsabo_addr), 64'h400);
      beat(0, FSAB_READ, 64'h500, 1, 0);
      beat(1, FSAB_READ, 64'h600, 1, 0);
      tick();
      cli_valid = '0;
      tick();
      chk("rr4_addr", 64'(fsabo_addr), 64'h600);
      chk("rr4_cred", 64'(cli_credit), 2);
      tick();
      chk("rr5_addr", 64'(fsabo_addr), 64'h500);
      chk("rr5_cred", 64'(cli_credit), 1);
      // write burst is not interleaved; a gap in client 1 stalls the port
      do_reset();
      beat(1, FSAB_WRITE, 64'h700, 4, 64'ha0);
      beat(0, FSAB_READ, 64'h10, 1, 0);
      tick();
      chk("wr_e1_valid", 64'(fsabo_valid), 0);
      beat(1, FSAB_WRITE, 64'h700, 4, 64'ha1);
      beat(0, FSAB_READ, 64'h11, 1, 0);
      tick();
      chk("wr_e2_addr", 64'(fsabo_addr), 64'h10);
      chk("wr_e2_cred", 64'(cli_credit), 1);
      cli_valid[1] = 1'b0;
      beat(0, FSAB_READ, 64'h12, 1, 0);
      tick();
      chk("wr_b0_data", 64'(fsabo_data), 64'ha0);
      chk("wr_b0_addr", 64'(fsabo_addr), 64'h700);
      chk("wr_b0_mode", 64'(fsabo_mode), 1);
      chk("wr_b0_cred", 64'(cli_credit), 2);
      beat(0, FSAB_READ, 64'h13, 1, 0);
      tick();
      chk("wr_b1_data", 64'(fsabo_data), 64'ha1);
      chk("wr_b1_cred", 64'(cli_credit), 2);
      cli_valid = '0;
      tick();
      chk("wr_stall1", 64'(fsabo_valid), 0);
      chk("wr_hold", 64'(fsabo_data), 64'ha1);
      beat(1, FSAB_WRITE, 64'h700, 4, 64'ha2);
      tick();
      chk("wr_stall2", 64'(fsabo_valid), 0);
      beat(1, FSAB_WRITE, 64'h700, 4, 64'ha3);
      tick();
      cli_valid = '0;
      chk("wr_b2_data", 64'(fsabo_data), 64'ha2);
      chk("wr_b2_valid", 64'(fsabo_valid), 1);
      tick();
      chk("wr_b3_data", 64'(fsabo_data), 64'ha3);
      chk("wr_b3_cred", 64'(cli_credit), 2);
      tick();
      chk("wr_after_addr", 64'(fsabo_addr), 64'h11);
      chk("wr_after_cred", 64'(cli_credit), 1);
      tick();
      chk("wr_after2_addr", 64'(fsabo_addr), 64'h12);
      // upstream credit exhaustion and FIFO overflow
      fsabo_credit = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         beat(0, FSAB_READ, 64'h20 + 64'(k), 1, 0);
         tick();
      end
      cli_valid = '0;
      tick();
      tick();
      chk("exh_upcred", 64'(dut.up_credits), 0);
      for (int k = 0; k < D + 1; k++) begin
         beat(0, FSAB_READ, 64'h30 + 64'(k), 1, 0);
         tick();
      end
      cli_valid = '0;
      chk("ovf_err", 64'(err_overflow), 1);
      tick();
      chk("exh_novalid", 64'(fsabo_valid), 0);
      fsabo_credit = 1'b1;
      tick();
      fsabo_credit = 1'b0;
      chk("one_cred_wait", 64'(fsabo_valid), 0);
      tick();
      chk("one_cred_valid", 64'(fsabo_valid), 1);
      chk("one_cred_addr", 64'(fsabo_addr), 64'h30);
      tick();
      chk("one_cred_only1", 64'(fsabo_valid), 0);
      tick();
      chk("one_cred_only2", 64'(fsabo_valid), 0);
      fsabo_credit = 1'b1;
      tick();
      tick();
      chk("drain_31", 64'(fsabo_addr), 64'h31);
      tick();
      chk("drain_32", 64'(fsabo_addr), 64'h32);
      tick();
      chk("drain_33", 64'(fsabo_addr), 64'h33);
      chk("drain_33_valid", 64'(fsabo_valid), 1);
      tick();
      chk("drain_dropped", 64'(fsabo_valid), 0);
      chk("ovf_sticky", 64'(err_overflow), 1);
      // reset during a write burst
      beat(1, FSAB_WRITE, 64'h800, 4, 64'hb0);
      tick();
      beat(1, FSAB_WRITE, 64'h800, 4, 64'hb1);
      tick();
      chk("rb_b0_data", 64'(fsabo_data), 64'hb0);
      cli_valid = '0;
      rst = 1'b1;
      tick();
      chk("rb_valid", 64'(fsabo_valid), 0);
      chk("rb_data", 64'(fsabo_data), 0);
      chk("rb_addr", 64'(fsabo_addr), 0);
      chk("rb_clicred", 64'(cli_credit), 0);
      chk("rb_err", 64'(err_overflow), 0);
      chk("rb_upcred", 64'(dut.up_credits), 4);
      rst = 1'b0;
      tick();
      tick();
      chk("rb_fifo_empty", 64'(fsabo_valid), 0);
      beat(0, FSAB_READ, 64'h900, 8, 0);
      tick();
      cli_valid = '0;
      tick();
      chk("rb_post_valid", 64'(fsabo_valid), 1);
      chk("rb_post_addr", 64'(fsabo_addr), 64'h900);
      chk("rb_post_len", 64'(fsabo_len), 8);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fsab_req_arbiter.md
Name: fsab_req_arbiter

Overview:
- Shares one FSAB request port between NCLIENT masters, e.g. several DMA read controllers plus a CPU-side port.
- Each client talks to the arbiter exactly as it would talk to FSAB: it issues valid beats against its own credit counter.
- The arbiter buffers beats per client and returns a credit to a client for each beat it drains.
- It round-robins at packet granularity onto the single upstream FSAB request port and keeps the upstream credit count.

Parameters:
- NCLIENT, 2, number of requesting masters (2..8).
- FIFO_DEPTH, FSAB_INITIAL_CREDITS, beats buffered per client; power of 2; equals the credits each client is born with.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cli_valid  in  NCLIENT  per-client beat strobe.
- cli_mode  in  NCLIENT*(FSAB_REQ_HI+1)  per-client request mode (FSAB_READ/FSAB_WRITE).
- cli_did, cli_subdid  in  NCLIENT*(FSAB_DID_HI+1)  per-client device/subdevice id.
- cli_addr  in  NCLIENT*(FSAB_ADDR_HI+1)  per-client address.
- cli_len  in  NCLIENT*(FSAB_LEN_HI+1)  per-client length in 64-bit beats.
- cli_data  in  NCLIENT*(FSAB_DATA_HI+1)  per-client write data.
- cli_mask  in  NCLIENT*(FSAB_MASK_HI+1)  per-client byte mask.
- cli_credit  out  NCLIENT  one-cycle credit return pulse per client.
- fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask  out  FSAB widths  upstream request port.
- fsabo_credit  in  1  upstream credit return.
- err_overflow  out  NCLIENT  sticky: a client pushed into a full FIFO.

Behaviour:
Reset (rst high at a clk edge):
- All FIFOs are emptied.
- up_credits = FSAB_INITIAL_CREDITS.
- Round-robin pointer = 0; grant released.
- All outputs = 0 (fsabo_valid, fsabo_* fields, cli_credit, err_overflow).
- Reset mid-packet drops partial packets. Clients must be reset in the same cycle.

Ingress:
- cli_valid[i] pushes that client's field slice into FIFO i in the same cycle, unconditionally.
- Push when FIFO i is full (and not popping the same cycle): the beat is dropped and err_overflow[i] is set until reset.
- Simultaneous push and pop on a full FIFO is legal.

Packet framing:
- Read = 1 beat.
- Write = cli_len beats. The first beat carries the header fields; later beats carry only data/mask.
- cli_len = 0 on a write is treated as 1.
- The arbiter latches beats_left from the head beat when it grants.

Arbitration:
- State IDLE: among clients with a non-empty FIFO, pick the first at or after rr_ptr (wrapping modulo NCLIENT).
  - Pop that client's head beat only if up_credits != 0.
  - Go to BURST if beats_left > 1; otherwise stay in IDLE and set rr_ptr = winner+1.
- State BURST: pop only from the granted client, one beat per cycle, when its FIFO is non-empty and up_credits != 0.
  - Decrement beats_left on each pop.
  - On the last beat: return to IDLE and set rr_ptr = winner+1.
  - An empty FIFO in BURST stalls: no valid, grant held, other clients wait.

Pop side effects:
- up_credits is decremented in the pop cycle.
- cli_credit[i] pulses in the cycle after the pop.
- The beat appears on fsabo_* with fsabo_valid=1 in the cycle after the pop (registered output; latency 1).
- The non-valid fsabo fields hold their last value.

Credit accounting:
- up_credits += fsabo_credit, −= pop, both in the same cycle (net 0 when both occur).
- Counter width is clog2(FSAB_INITIAL_CREDITS)+1.
- A credit return that would exceed FSAB_INITIAL_CREDITS saturates at that value.

Throughput: one beat per cycle maximum, when credits allow.

Decomposition:
- fsab_defines.vh (shared) supplies FSAB_*_HI, FSAB_READ/FSAB_WRITE and FSAB_INITIAL_CREDITS.
- clog2.vh supplies counter widths.
- Sub-module fsab_arb_fifo: synchronous FIFO of packed beat words, with push/pop/full/empty/head outputs.
  - Instantiated NCLIENT times via generate.
  - Packed beat width is the sum of the FSAB field widths; the packing constant lives in the shared defines.

Test Plan:
- Single client 0 issues a read at addr 0x100, len 8. → fsabo_valid 2 cycles after cli_valid, addr 0x100, len 8; cli_credit[0] pulses once; up_credits returns to initial after fsabo_credit.
- Clients 0 and 1 both issue reads in the same cycle; rr_ptr=0. → grant order client 0, then client 1; the next simultaneous pair goes 1 then 0.
- Client 1 writes len 4 while client 0 streams reads. → 4 consecutive client-1 beats on fsabo with no client-0 beat interleaved; client 1 delays beat 3 by 2 cycles and fsabo stalls for 2 cycles.
- Upstream holds fsabo_credit low until credits reach 0. → no fsabo_valid issued; one fsabo_credit pulse releases exactly one beat.
- Client 0 pushes FIFO_DEPTH+1 beats with no credits upstream. → err_overflow[0]=1; exactly FIFO_DEPTH beats are later forwarded.
- Assert rst during a write burst. → all outputs 0 the next cycle; FIFOs empty; the first post-reset request is forwarded normally.
